// File: rtl/ssd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ssd_pkg
// Description : Shared types and constants for the seven-segment display
//               driver: converter states, sizes and segment patterns.
// Revision    : 1.0 - initial release
// ============================================================================
package ssd_pkg;

    localparam int c_NUM_DIGITS = 4;
    localparam int c_VALUE_W    = 13;
    localparam int c_BCD_W      = 4 * c_NUM_DIGITS;
    localparam int c_STEP_W     = 4;

    localparam logic [1:0] c_ST_LOAD   = 2'd0;
    localparam logic [1:0] c_ST_CONV   = 2'd1;
    localparam logic [1:0] c_ST_COMMIT = 2'd2;

    typedef enum logic [1:0] {
        ST_LOAD   = c_ST_LOAD,
        ST_CONV   = c_ST_CONV,
        ST_COMMIT = c_ST_COMMIT
    } conv_state_t;

    // Active-low segments ordered {a,b,c,d,e,f,g}
    localparam logic [6:0] c_SEG_0     = 7'b0000001;
    localparam logic [6:0] c_SEG_1     = 7'b1001111;
    localparam logic [6:0] c_SEG_2     = 7'b0010010;
    localparam logic [6:0] c_SEG_3     = 7'b0000110;
    localparam logic [6:0] c_SEG_4     = 7'b1001100;
    localparam logic [6:0] c_SEG_5     = 7'b0100100;
    localparam logic [6:0] c_SEG_6     = 7'b0100000;
    localparam logic [6:0] c_SEG_7     = 7'b0001111;
    localparam logic [6:0] c_SEG_8     = 7'b0000000;
    localparam logic [6:0] c_SEG_9     = 7'b0000100;
    localparam logic [6:0] c_SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = c_SEG_0;
            4'd1:    seg = c_SEG_1;
            4'd2:    seg = c_SEG_2;
            4'd3:    seg = c_SEG_3;
            4'd4:    seg = c_SEG_4;
            4'd5:    seg = c_SEG_5;
            4'd6:    seg = c_SEG_6;
            4'd7:    seg = c_SEG_7;
            4'd8:    seg = c_SEG_8;
            4'd9:    seg = c_SEG_9;
            default: seg = c_SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_bcd_seq
// Description : Free-running sequential double-dabble converter, one shift
//               per cycle, committing a 4-digit BCD result every 15 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq
    import ssd_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [c_VALUE_W-1:0] value,
    output logic [c_BCD_W-1:0]   bcd,
    output logic                 busy
);

    localparam logic [c_STEP_W-1:0] c_LAST_STEP = c_STEP_W'(c_VALUE_W - 1);

    conv_state_t          r_state;
    conv_state_t          w_state_nxt;
    logic [c_VALUE_W-1:0] r_bin;
    logic [c_BCD_W-1:0]   r_scratch;
    logic [c_BCD_W-1:0]   r_bcd;
    logic [c_STEP_W-1:0]  r_step;
    logic [c_BCD_W-1:0]   w_adj;
    logic                 w_busy;

    // Add-3 correction on every nibble that would overflow past 9 when doubled
    for (genvar g = 0; g < c_NUM_DIGITS; g++) begin : g_adj
        assign w_adj[4*g +: 4] = (r_scratch[4*g +: 4] >= 4'd5) ?
                                 r_scratch[4*g +: 4] + 4'd3 :
                                 r_scratch[4*g +: 4];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b1;
        case (r_state)
            ST_LOAD: begin
                w_state_nxt = ST_CONV;
                w_busy      = 1'b0;
            end
            ST_CONV: begin
                if (r_step == c_LAST_STEP) begin
                    w_state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: w_state_nxt = ST_LOAD;
            default:   w_state_nxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_LOAD;
            r_bin     <= '0;
            r_scratch <= '0;
            r_step    <= '0;
            r_bcd     <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_LOAD: begin
                    r_bin     <= value;
                    r_scratch <= '0;
                    r_step    <= '0;
                end
                ST_CONV: begin
                    {r_scratch, r_bin} <= {w_adj, r_bin} << 1;
                    r_step             <= r_step + 1'b1;
                end
                ST_COMMIT: r_bcd <= r_scratch;
                default: ;
            endcase
        end
    end

    assign bcd  = r_bcd;
    assign busy = w_busy;

endmodule
`default_nettype wire

// File: rtl/ssd_driver.sv
`default_nettype none
// ============================================================================
// Module      : ssd_driver
// Description : Binary-to-BCD conversion and multiplexed common-anode 4-digit
//               seven-segment scan with optional leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_driver
    import ssd_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int BLANK_LZ = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [c_VALUE_W-1:0] value,
    output logic [3:0]           anode,
    output logic [6:0]           cathode,
    output logic [c_BCD_W-1:0]   bcd,
    output logic                 busy
);

    localparam int                 c_PRE_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(SCAN_DIV - 1);

    logic [c_PRE_W-1:0] r_pre;
    logic [1:0]         r_idx;
    logic [c_BCD_W-1:0] w_bcd;
    logic [c_BCD_W-1:0] w_upper;
    logic [3:0]         w_digit;
    logic               w_blank;

    bin_to_bcd_seq u_conv (
        .clk   (clk),
        .rst   (rst),
        .value (value),
        .bcd   (w_bcd),
        .busy  (busy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (r_pre == c_PRE_MAX) begin
            r_pre <= '0;
            r_idx <= r_idx + 1'b1;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // Selected digit and everything above it; all-zero means a leading zero
    assign w_upper = w_bcd >> {r_idx, 2'b00};
    assign w_digit = w_upper[3:0];
    assign w_blank = (BLANK_LZ != 0) && (r_idx != 2'd0) && (w_upper == '0);

    assign anode   = ~(4'b0001 << r_idx);
    assign cathode = w_blank ? c_SEG_BLANK : seg_decode(w_digit);
    assign bcd     = w_bcd;

endmodule
`default_nettype wire

// File: tb/tb_ssd_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssd_driver
// Description : Directed self-checking bench for ssd_driver (blanking on and
//               off instances sharing clock, reset and input).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ssd_driver;

    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] value = 13'd1234;
    logic [3:0]  anode, anode_nz;
    logic [6:0]  cathode, cathode_nz;
    logic [15:0] bcd, bcd_nz;
    logic        busy, busy_nz;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ssd_driver #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1)) dut (
        .clk(clk), .rst(rst), .value(value),
        .anode(anode), .cathode(cathode), .bcd(bcd), .busy(busy)
    );

    ssd_driver #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(0)) dut_nz (
        .clk(clk), .rst(rst), .value(value),
        .anode(anode_nz), .cathode(cathode_nz), .bcd(bcd_nz), .busy(busy_nz)
    );

    typedef struct {
        logic [12:0] value;
        logic [15:0] bcd;
        logic [15:0] shown;   // nibble F = blanked digit
    } vec_t;

    vec_t vecs[8];

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'b0000001;
            4'd1: return 7'b1001111;
            4'd2: return 7'b0010010;
            4'd3: return 7'b0000110;
            4'd4: return 7'b1001100;
            4'd5: return 7'b0100100;
            4'd6: return 7'b0100000;
            4'd7: return 7'b0001111;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        check({name, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic check_digits(input string name, input logic [15:0] exp_bcd, input logic [15:0] shown);
        for (int i = 0; i < 4; i++) begin
            logic [3:0] want_an;
            int n;
            want_an = ~(4'b0001 << i);
            n = 0;
            while (anode !== want_an && n < 4 * SCAN_DIV + 2) begin
                tick();
                n++;
            end
            check($sformatf("%s_anode%0d", name, i), {28'd0, anode}, {28'd0, want_an});
            check($sformatf("%s_anode_nz%0d", name, i), {28'd0, anode_nz}, {28'd0, want_an});
            check($sformatf("%s_seg%0d", name, i), {25'd0, cathode}, {25'd0, seg(shown[4*i +: 4])});
            check($sformatf("%s_seg_nz%0d", name, i), {25'd0, cathode_nz}, {25'd0, seg(exp_bcd[4*i +: 4])});
        end
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_anode"}, {28'd0, anode}, 32'b1110);
        check({name, "_cathode"}, {25'd0, cathode}, 32'b0000001);
        check({name, "_bcd"}, {16'd0, bcd}, 32'h0);
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [15:0] basic;
        basic = 16'h1234;

        vecs[0] = '{13'd1234, 16'h1234, 16'h1234};
        vecs[1] = '{13'd8191, 16'h8191, 16'h8191};
        vecs[2] = '{13'd7,    16'h0007, 16'hFFF7};
        vecs[3] = '{13'd0,    16'h0000, 16'hFFF0};
        vecs[4] = '{13'd50,   16'h0050, 16'hFF50};
        vecs[5] = '{13'd905,  16'h0905, 16'hF905};
        vecs[6] = '{13'd1000, 16'h1000, 16'h1000};
        vecs[7] = '{13'd4096, 16'h4096, 16'h4096};

        // Reset held for 3 edges with value 1234 already applied
        repeat (3) tick();
        check_reset_state("reset");
        rst = 1'b0;

        // Edge 1 is the first LOAD; commit lands on edge 15
        tick();
        check("busy_after_load", {31'd0, busy}, 32'd1);
        repeat (13) tick();
        check("bcd_before_commit", {16'd0, bcd}, 32'h0);
        check("busy_in_commit", {31'd0, busy}, 32'd1);
        tick();
        check("bcd_first_commit", {16'd0, bcd}, 32'h1234);
        check("busy_back_in_load", {31'd0, busy}, 32'd0);

        // Index wrapped to 3 at edge 12; a fresh frame starts at edge 16
        tick();
        for (int c = 0; c < 16; c++) begin
            int idx;
            logic [3:0] want_an;
            idx = c / SCAN_DIV;
            want_an = ~(4'b0001 << idx);
            check($sformatf("scan_anode_c%0d", c), {28'd0, anode}, {28'd0, want_an});
            check($sformatf("scan_seg_c%0d", c), {25'd0, cathode}, {25'd0, seg(basic[4*idx +: 4])});
            tick();
        end

        for (int v = 0; v < 8; v++) begin
            value = vecs[v].value;
            repeat (31) tick();
            check($sformatf("vec%0d_bcd", v), {16'd0, bcd}, {16'd0, vecs[v].bcd});
            check($sformatf("vec%0d_bcd_nz", v), {16'd0, bcd_nz}, {16'd0, vecs[v].bcd});
            check_digits($sformatf("vec%0d", v), vecs[v].bcd, vecs[v].shown);
        end

        // Change during the 5th CONV cycle must not corrupt the running conversion
        wait_idle("midchg");
        value = 13'd100;
        tick();
        repeat (4) tick();
        value = 13'd200;
        repeat (9) tick();
        check("midchg_hold_old", {16'd0, bcd}, 32'h4096);
        tick();
        check("midchg_commit_100", {16'd0, bcd}, 32'h0100);
        repeat (14) tick();
        check("midchg_still_100", {16'd0, bcd}, 32'h0100);
        tick();
        check("midchg_commit_200", {16'd0, bcd}, 32'h0200);

        // One-cycle reset at CONV step 7 aborts; restart commits 15 edges later
        wait_idle("rstconv");
        value = 13'd4321;
        tick();
        repeat (6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state("rstconv");
        for (int c = 0; c < 14; c++) begin
            tick();
            check($sformatf("rstconv_hold_c%0d", c), {16'd0, bcd}, 32'h0);
        end
        tick();
        check("rstconv_commit", {16'd0, bcd}, 32'h4321);

        // Three-cycle reset in the middle of operation
        value = 13'd8191;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check_reset_state("rst3_first");
        repeat (2) tick();
        check_reset_state("rst3_last");
        rst = 1'b0;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
